// File: rtl/rv32_issue_scoreboard.sv
// rv32_issue_scoreboard
// Issue controller between decode and execute. A small saturating counter per
// architectural register tracks writes that have issued but not yet retired.
// A decoded instruction is held while it reads a register with a pending write
// (RAW), while its destination counter is full, or, for serialising
// instructions, until no write is outstanding at all (DRAIN state).
module rv32_issue_scoreboard #(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [4:0]        i_id_rs1,
  input  logic [4:0]        i_id_rs2,
  input  logic [1:0]        i_id_use_rs,
  input  logic [4:0]        i_id_rd,
  input  logic              i_id_register_wb,
  input  logic              i_id_serialize,
  input  logic              i_id_flush,
  input  logic              i_ex_ready,
  input  logic              i_rt_valid,
  input  logic [4:0]        i_rt_rd,
  output logic              o_id_issue,
  output logic              o_id_stall,
  output logic              o_sb_busy,
  output logic              o_sb_state,
  output logic              o_sb_err,
  output logic [PERF_W-1:0] o_stall_cycles
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Entry 0 is reset and never incremented, so x0 always reads as idle.
  logic [CNT_W-1:0]  r_cnt [32];
  state_t            r_state;
  logic              r_err;
  logic [PERF_W-1:0] r_stall_cycles;

  state_t w_state_nxt;
  logic   w_busy;
  logic   w_raw;
  logic   w_sat;
  logic   w_ser_ok;
  logic   w_fire_ok;
  logic   w_issue;
  logic   w_stall;
  logic   w_inc;
  logic   w_dec;
  logic   w_same;
  logic   w_dec_ok;
  logic   w_err_set;

  // Scoreboard is busy while any tracked register has a write in flight.
  always_comb begin
    w_busy = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (r_cnt[i] != '0) w_busy = 1'b1;
    end
  end

  // Hazards are evaluated from registered counts only; a retire in this same
  // cycle does not release the held instruction until the next cycle.
  assign w_raw = (i_id_use_rs[0] & (i_id_rs1 != 5'd0) & (r_cnt[i_id_rs1] != '0))
               | (i_id_use_rs[1] & (i_id_rs2 != 5'd0) & (r_cnt[i_id_rs2] != '0));
  assign w_sat = i_id_register_wb & (i_id_rd != 5'd0) & (r_cnt[i_id_rd] == CNT_MAX);
  assign w_ser_ok  = ~i_id_serialize | ~w_busy;
  assign w_fire_ok = i_id_valid & ~i_id_flush & i_ex_ready & ~w_raw & ~w_sat & w_ser_ok;

  // Issue decision and next-state: RUN issues anything that is hazard free;
  // DRAIN only lets the waiting serialising instruction through.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_issue = w_fire_ok;
        if (i_id_valid & i_id_serialize & ~i_id_flush & w_busy) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_issue = w_fire_ok & i_id_serialize;
        if (~i_id_valid | i_id_flush | ~i_id_serialize | w_issue) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_stall  = i_id_valid & ~w_issue & ~i_id_flush;
  assign w_inc    = w_issue & i_id_register_wb & (i_id_rd != 5'd0);
  assign w_dec    = i_rt_valid & (i_rt_rd != 5'd0);
  assign w_same   = w_inc & w_dec & (i_id_rd == i_rt_rd);
  assign w_dec_ok = w_dec & ~w_same & (r_cnt[i_rt_rd] != '0);
  assign w_err_set = w_dec & ~w_same & (r_cnt[i_rt_rd] == '0);

  // FSM state register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (i_rst) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Per-register pending-write counters; an issue and a retire to the same
  // register in one cycle cancel out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: this counter array is deliberately reset in full; stale counts
      // after reset would stall decode forever.
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      if (w_inc & ~w_same) r_cnt[i_id_rd] <= r_cnt[i_id_rd] + CNT_ONE;
      if (w_dec_ok)        r_cnt[i_rt_rd] <= r_cnt[i_rt_rd] - CNT_ONE;
    end
  end

  // Sticky error flag for a retire that matches no in-flight write.
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge i_clk) begin
    if (i_rst)                             r_stall_cycles <= '0;
    else if (w_stall & ~&r_stall_cycles)   r_stall_cycles <= r_stall_cycles + PERF_W'(1);
  end

  assign o_id_issue     = w_issue;
  assign o_id_stall     = w_stall;
  assign o_sb_busy      = w_busy;
  assign o_sb_state     = r_state;
  assign o_sb_err       = r_err;
  assign o_stall_cycles = r_stall_cycles;

endmodule
